// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: 16550-class UART transmitter.
//   - divisor-driven baud tick generator (OVERSAMPLE ticks per bit time)
//   - TX FIFO (FIFO_DEPTH entries, or a 1-entry holding register when fifo_en=0)
//   - frame FSM: start, 5..8-style data bits LSB first, optional parity, 1/1.5/2 stop, break
// Optional feature macro: UART_TX_CTS_EN adds an active-low cts_n input that
// gates the start of new frames.
module uart_tx_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              divisor,
  input  logic [1:0]                    wls,
  input  logic                          stb,
  input  logic                          pen,
  input  logic                          eps,
  input  logic                          sp,
  input  logic                          bc,
  input  logic                          fifo_en,
  input  logic                          fifo_clr,
  input  logic                          wr,
  input  logic [DATA_W-1:0]             din,
  input  logic                          overrun_clr,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  output logic                          tx,
  output logic                          baud_pulse,
  output logic                          thre,
  output logic                          temt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam int TW = $clog2(2 * OVERSAMPLE + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------- baud tick
  logic [DIV_W-1:0] baud_cnt_reg;
  logic             baud_pulse_reg;

  // Down-counter: reload divisor-1 and tick on terminal count; divisor=0 parks it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_reg   <= '0;
      baud_pulse_reg <= 1'b0;
    end else if (divisor == '0) begin
      baud_cnt_reg   <= '0;
      baud_pulse_reg <= 1'b0;
    end else if (baud_cnt_reg == '0) begin
      baud_cnt_reg   <= divisor - DIV_W'(1);
      baud_pulse_reg <= 1'b1;
    end else begin
      baud_cnt_reg   <= baud_cnt_reg - DIV_W'(1);
      baud_pulse_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- CTS gating
  logic cts_ok;
`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_reg;

  // Two-flop synchroniser; resets to "not clear to send"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cts_sync_reg <= 2'b11;
    else        cts_sync_reg <= {cts_sync_reg[0], cts_n};
  end
  assign cts_ok = ~cts_sync_reg[1];
`else
  assign cts_ok = 1'b1;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     level_reg, level_next;
  logic              fifo_en_reg;
  logic              overrun_reg;
  logic              flush, full, push, pop, overflow;

  // A mode change empties the queue just like an explicit clear
  assign flush    = fifo_clr | (fifo_en != fifo_en_reg);
  assign full     = fifo_en ? (level_reg == LW'(FIFO_DEPTH)) : (level_reg != '0);
  assign push     = wr & ~full & ~flush;
  assign overflow = wr & full & ~flush;

  // Storage array, written on push only (no reset so it maps to RAM)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  // Occupancy: clear wins; simultaneous push and pop leave it unchanged
  always_comb begin
    level_next = level_reg;
    if (flush)              level_next = '0;
    else if (push && !pop)  level_next = level_reg + LW'(1);
    else if (!push && pop)  level_next = level_reg - LW'(1);
  end

  // ---------------------------------------------------------------- frame config
  logic [BW-1:0]     cfg_wlen;
  logic [DATA_W-1:0] cfg_mask;
  logic [DATA_W-1:0] load_data;
  logic              load_par;
  logic [TW-1:0]     cfg_stop;

  assign cfg_wlen = BW'(DATA_W - 3) + BW'(wls);

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
      assign cfg_mask[gi] = (BW'(gi) < cfg_wlen);
    end
  endgenerate

  // Head of queue, trimmed to the word length so parity only covers sent bits
  assign load_data = mem[rd_ptr_reg] & cfg_mask;
  assign load_par  = sp ? ~eps : (eps ? ^load_data : ~^load_data);
  assign cfg_stop  = !stb ? TW'(OVERSAMPLE)
                   : (wls == 2'd0) ? TW'(OVERSAMPLE + OVERSAMPLE / 2)
                   : TW'(2 * OVERSAMPLE);

  // ---------------------------------------------------------------- FSM
  state_t            state_reg, state_next;
  logic [TW-1:0]     tick_reg, tick_next;
  logic [BW-1:0]     bit_reg, bit_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              par_reg, par_next;
  logic              pen_reg, pen_next;
  logic [BW-1:0]     wlen_reg, wlen_next;
  logic [TW-1:0]     stop_reg, stop_next;
  logic              start_ok;
  logic              line_bit;
  logic              tx_reg, thre_reg, temt_reg;

  assign start_ok = baud_pulse_reg & (level_reg != '0) & cts_ok & ~flush;

  // Next-state logic: dwell counted in baud ticks, config latched at each pop
  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    pen_next   = pen_reg;
    wlen_next  = wlen_reg;
    stop_next  = stop_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          pop        = 1'b1;
          shift_next = load_data;
          par_next   = load_par;
          pen_next   = pen;
          wlen_next  = cfg_wlen;
          stop_next  = cfg_stop;
          tick_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_pulse_reg) begin
          if (tick_reg == TW'(OVERSAMPLE - 1)) begin
            tick_next  = '0;
            bit_next   = '0;
            state_next = DATA;
          end else begin
            tick_next = tick_reg + TW'(1);
          end
        end
      end
      DATA: begin
        if (baud_pulse_reg) begin
          if (tick_reg == TW'(OVERSAMPLE - 1)) begin
            tick_next  = '0;
            shift_next = shift_reg >> 1;
            if (bit_reg == wlen_reg - BW'(1)) state_next = pen_reg ? PARITY : STOP;
            else                              bit_next   = bit_reg + BW'(1);
          end else begin
            tick_next = tick_reg + TW'(1);
          end
        end
      end
      PARITY: begin
        if (baud_pulse_reg) begin
          if (tick_reg == TW'(OVERSAMPLE - 1)) begin
            tick_next  = '0;
            state_next = STOP;
          end else begin
            tick_next = tick_reg + TW'(1);
          end
        end
      end
      STOP: begin
        if (baud_pulse_reg) begin
          if (tick_reg == stop_reg - TW'(1)) begin
            tick_next = '0;
            if (start_ok) begin
              pop        = 1'b1;
              shift_next = load_data;
              par_next   = load_par;
              pen_next   = pen;
              wlen_next  = cfg_wlen;
              stop_next  = cfg_stop;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_next = tick_reg + TW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level implied by the current state (break is applied at the register)
  always_comb begin
    line_bit = 1'b1;
    case (state_reg)
      START:   line_bit = 1'b0;
      DATA:    line_bit = shift_reg[0];
      PARITY:  line_bit = par_reg;
      default: line_bit = 1'b1;
    endcase
  end

  // State, queue pointers, sticky overrun and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      par_reg     <= 1'b0;
      pen_reg     <= 1'b0;
      wlen_reg    <= '0;
      stop_reg    <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      fifo_en_reg <= 1'b0;
      overrun_reg <= 1'b0;
      tx_reg      <= 1'b1;
      thre_reg    <= 1'b1;
      temt_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      par_reg     <= par_next;
      pen_reg     <= pen_next;
      wlen_reg    <= wlen_next;
      stop_reg    <= stop_next;
      fifo_en_reg <= fifo_en;
      level_reg   <= level_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (overflow)         overrun_reg <= 1'b1;
      else if (overrun_clr) overrun_reg <= 1'b0;
      tx_reg   <= bc ? 1'b0 : line_bit;
      thre_reg <= (level_next == '0);
      temt_reg <= (level_next == '0) && (state_next == IDLE);
    end
  end

  assign tx         = tx_reg;
  assign baud_pulse = baud_pulse_reg;
  assign thre       = thre_reg;
  assign temt       = temt_reg;
  assign fifo_level = level_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Testbench for uart_tx_fifo_param: table of single-frame vectors plus
// hand-written sequences for queue overflow, clear, holding mode, break and reset.
module tb_uart_tx_fifo_param;
  localparam int DATA_W = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV_W = 16;
  localparam int OVERSAMPLE = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIV_W-1:0]  divisor = '0;
  logic [1:0]        wls = 2'd3;
  logic              stb = 1'b0, pen = 1'b0, eps = 1'b0, sp = 1'b0, bc = 1'b0;
  logic              fifo_en = 1'b1, fifo_clr = 1'b0, wr = 1'b0, overrun_clr = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              cts_n = 1'b0;
  logic              tx, baud_pulse, thre, temt, overrun;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  uart_tx_fifo_param #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W),
                       .OVERSAMPLE(OVERSAMPLE)) dut (
    .clk(clk), .rst_n(rst_n), .divisor(divisor), .wls(wls), .stb(stb), .pen(pen),
    .eps(eps), .sp(sp), .bc(bc), .fifo_en(fifo_en), .fifo_clr(fifo_clr), .wr(wr),
    .din(din), .overrun_clr(overrun_clr),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_n),
`endif
    .tx(tx), .baud_pulse(baud_pulse), .thre(thre), .temt(temt),
    .fifo_level(fifo_level), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int low_total = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (tx == 1'b0) low_total++;

  int checks = 0;
  int failures = 0;
  int last_fall = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] wls;
    logic       pen, eps, sp, stb;
    logic       exp_par;
    int         exp_total;   // frame length in clk (divisor=2)
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_fall(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        ok = 1'b1;
        last_fall = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL start_timeout: got no start bit expected one within 2000 clk");
  endtask

  // Returns on the stop-bit midpoint; t counts negedges since the start edge
  task automatic rx_frame(input int nbits, input logic with_par, output logic [7:0] data,
                          output logic parb, output logic stopb, output logic s31,
                          output logic s32, output int t, output logic ok);
    int k;
    int last;
    data = '0; parb = 1'b0; stopb = 1'b0; s31 = 1'b0; s32 = 1'b0; t = 0;
    wait_fall(ok);
    if (!ok) return;
    last = 16 + 32 * (nbits + 1 + (with_par ? 1 : 0));
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      t = i;
      if (i == 31) s31 = tx;
      if (i == 32) s32 = tx;
      if (i >= 48 && ((i - 16) % 32) == 0) begin
        k = (i - 16) / 32;
        if (k <= nbits)                          data[k-1] = tx;
        else if (with_par && k == nbits + 1)     parb = tx;
        else                                     stopb = tx;
      end
    end
  endtask

  task automatic wait_temt(inout int t);
    for (int i = 0; i < 400; i++) begin
      if (temt == 1'b1) return;
      @(negedge clk);
      t++;
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1; din = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic pb, sb, s31, s32, ok;
    int t, l0, c0;

    vecs[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 320};
    vecs[1] = '{8'hA5, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 352};
    vecs[2] = '{8'h5A, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 352};
    vecs[3] = '{8'hFF, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 352};
    vecs[4] = '{8'hFF, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 352};
    vecs[5] = '{8'h15, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 240};
    vecs[6] = '{8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 352};
    vecs[7] = '{8'hC7, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 288};

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_baud_pulse", baud_pulse, 0);
    chk("rst_thre", thre, 1);
    chk("rst_temt", temt, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_tx", tx, 1);
    chk("idle_baud_pulse_div0", baud_pulse, 0);

    // ---- single-frame vectors, divisor=2
    divisor = 16'd2;
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      wls = vecs[v].wls; pen = vecs[v].pen; eps = vecs[v].eps;
      sp = vecs[v].sp; stb = vecs[v].stb;
      write_byte(vecs[v].data);
      rx_frame(int'(vecs[v].wls) + 5, vecs[v].pen, rd, pb, sb, s31, s32, t, ok);
      if (ok) begin
        chk($sformatf("v%0d_data", v), rd,
            vecs[v].data & ((8'd1 << (int'(vecs[v].wls) + 5)) - 8'd1));
        if (vecs[v].pen) chk($sformatf("v%0d_parity", v), pb, vecs[v].exp_par);
        chk($sformatf("v%0d_stop_mid", v), sb, 1);
        if (vecs[v].data[0]) begin
          chk($sformatf("v%0d_start_last_low", v), s31, 0);
          chk($sformatf("v%0d_start_end_high", v), s32, 1);
        end
        wait_temt(t);
        chk_range($sformatf("v%0d_frame_len", v), t + 1, vecs[v].exp_total - 1,
                  vecs[v].exp_total + 2);
      end
      $display("vec %0d data=0x%02h wls=%0d pen=%0d eps=%0d sp=%0d stb=%0d rx=0x%02h par=%0b len=%0d",
               v, vecs[v].data, vecs[v].wls, vecs[v].pen, vecs[v].eps, vecs[v].sp,
               vecs[v].stb, rd, pb, t + 1);
    end

    // ---- flush with a simultaneous write: clear wins
    @(negedge clk);
    wls = 2'd3; pen = 1'b0; eps = 1'b0; sp = 1'b0; stb = 1'b0;
    divisor = '0;
    for (int i = 0; i < 3; i++) write_byte(8'h40 + 8'(i));
    chk("clr_pre_level", fifo_level, 3);
    @(negedge clk);
    fifo_clr = 1'b1; wr = 1'b1; din = 8'h77;
    @(negedge clk);
    fifo_clr = 1'b0; wr = 1'b0;
    chk("clr_level", fifo_level, 0);
    chk("clr_thre", thre, 1);
    chk("clr_overrun", overrun, 0);
    divisor = 16'd2;
    l0 = low_total;
    repeat (400) @(negedge clk);
    chk("clr_no_frame", low_total - l0, 0);
    $display("flush: level=%0d overrun=%0b", fifo_level, overrun);

    // ---- overflow then back-to-back drain
    divisor = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr = 1'b1; din = 8'(i);
    end
    @(negedge clk);
    wr = 1'b0;
    chk("ovf_level", fifo_level, 16);
    chk("ovf_overrun", overrun, 1);
    chk("ovf_thre", thre, 0);
    wr = 1'b1; din = 8'hEE; overrun_clr = 1'b1;
    @(negedge clk);
    wr = 1'b0; overrun_clr = 1'b0;
    chk("ovf_clr_vs_set", overrun, 1);
    divisor = 16'd2;
    c0 = 0;
    for (int k = 0; k < 16; k++) begin
      rx_frame(8, 1'b0, rd, pb, sb, s31, s32, t, ok);
      if (!ok) break;
      chk($sformatf("burst%0d_data", k), rd, 8'(k));
      if (k > 0) chk($sformatf("burst%0d_gap", k), last_fall - c0, 320);
      c0 = last_fall;
      $display("burst frame %0d rx=0x%02h", k, rd);
    end
    t = 0;
    wait_temt(t);
    l0 = low_total;
    repeat (400) @(negedge clk);
    chk("burst_no_extra", low_total - l0, 0);
    chk("burst_level", fifo_level, 0);
    chk("burst_overrun_sticky", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("burst_overrun_cleared", overrun, 0);

    // ---- holding-register mode, overflow, break mid-frame
    divisor = '0;
    fifo_en = 1'b0;
    @(negedge clk);
    wr = 1'b1; din = 8'h33;
    @(negedge clk);
    din = 8'h44;
    @(negedge clk);
    wr = 1'b0;
    chk("hold_level", fifo_level, 1);
    chk("hold_overrun", overrun, 1);
    divisor = 16'd2;
    wait_fall(ok);
    if (ok) begin
      t = 0;
      repeat (40) begin @(negedge clk); t++; end
      chk("hold_bit0_before_break", tx, 1);
      bc = 1'b1;
      @(negedge clk); t++;
      chk("break_tx_low", tx, 0);
      wait_temt(t);
      chk_range("break_frame_len", t + 1, 319, 322);
      chk("break_held_low", tx, 0);
      bc = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("break_release_tx", tx, 1);
      chk("hold_drained", fifo_level, 0);
      $display("break: frame_len=%0d", t + 1);
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;

    // ---- asynchronous reset during data bit 3 with bytes queued
    divisor = '0;
    fifo_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr = 1'b1; din = 8'h11 * 8'(i + 1);
    end
    @(negedge clk);
    wr = 1'b0;
    divisor = 16'd2;
    wait_fall(ok);
    if (ok) begin
      repeat (144) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_tx", tx, 1);
      chk("arst_level", fifo_level, 0);
      chk("arst_temt", temt, 1);
      @(negedge clk);
      rst_n = 1'b1;
      l0 = low_total;
      repeat (500) @(negedge clk);
      chk("arst_no_frame", low_total - l0, 0);
      $display("reset mid-frame: level=%0d tx=%0b", fifo_level, tx);
    end

`ifdef UART_TX_CTS_EN
    // ---- clear-to-send holds a queued byte
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    l0 = low_total;
    write_byte(8'h96);
    repeat (200) @(negedge clk);
    chk("cts_hold_no_frame", low_total - l0, 0);
    chk("cts_hold_level", fifo_level, 1);
    @(negedge clk);
    cts_n = 1'b0;
    c0 = cyc;
    rx_frame(8, 1'b0, rd, pb, sb, s31, s32, t, ok);
    if (ok) begin
      chk_range("cts_start_latency", last_fall - c0, 3, 6);
      chk("cts_data", rd, 8'h96);
      $display("cts: latency=%0d rx=0x%02h", last_fall - c0, rd);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
